// File: rtl/sm2_pkg.sv
// Shared SM2 definitions: field prime, default operand width and the arbiter FSM state type.
package sm2_pkg;

  localparam int unsigned W_DEFAULT = 256;

  localparam logic [255:0] P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StResp
  } state_e;

  // Width of a binary requester id; never zero so single-requester builds stay legal.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set bit of i_req searching upward from i_ptr with wrap-around.
module rr_arbiter import sm2_pkg::*; #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_id,
  output logic            o_valid
);

  int w_idx;

  // Walk offsets from farthest to nearest so the closest requester to i_ptr wins last.
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % int'(NREQ);
      if (i_req[w_idx]) begin
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
        o_id           = IDW'(w_idx);
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_inv_arbiter.sv
// Round-robin front end sharing one external mod-p inverse engine among NREQ requesters.
// Optional MOD_INV_ARB_ZERO_CHECK_EN answers operands 0 and p with an error, bypassing the engine.
module mod_inv_arbiter import sm2_pkg::*; #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = W_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [W-1:0]      resp_c,
  output logic              resp_err,
  output logic [W-1:0]      inv_a,
  output logic              inv_start,
  input  logic [W-1:0]      inv_c,
  input  logic              inv_done,
  output logic              busy
);

  localparam int unsigned IDW = id_width(NREQ);

  state_e          r_state;
  state_e          w_state_next;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  w_id;
  logic [NREQ-1:0] w_grant;
  logic            w_gvalid;
  logic            w_accept;
  logic            w_skip;
  logic [W-1:0]    w_op;
  logic [W-1:0]    r_inv_a;
  logic [W-1:0]    r_resp_c;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_id),
    .o_valid (w_gvalid)
  );

  assign w_op     = req_a[w_id*W +: W];
  assign w_accept = rstn && (r_state == StIdle) && w_gvalid;

`ifdef MOD_INV_ARB_ZERO_CHECK_EN
  localparam logic [W-1:0] PW = W'(P);

  logic r_resp_err;

  assign w_skip   = (w_op == '0) || (w_op == PW);
  assign resp_err = r_resp_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_resp_err <= 1'b0;
    end else if (w_accept) begin
      r_resp_err <= w_skip;
    end else if (r_state == StWait && inv_done) begin
      r_resp_err <= 1'b0;
    end
  end
`else
  assign w_skip   = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    resp_valid   = '0;
    inv_start    = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
        // Gated by rstn so nothing is offered while reset is held.
        if (rstn) begin
          req_ready = w_grant;
        end
        if (w_accept) begin
          w_state_next = w_skip ? StResp : StStart;
        end
      end
      StStart: begin
        inv_start    = 1'b1;
        w_state_next = StWait;
      end
      StWait: begin
        if (inv_done) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        resp_valid[r_id] = 1'b1;
        if (resp_ready[r_id]) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_inv_a  <= '0;
      r_resp_c <= '0;
    end else begin
      if (w_accept) begin
        r_inv_a <= w_op;
        r_id    <= w_id;
        r_ptr   <= (w_id == IDW'(NREQ - 1)) ? '0 : w_id + 1'b1;
        if (w_skip) begin
          r_resp_c <= '0;
        end
      end
      if (r_state == StWait && inv_done) begin
        r_resp_c <= inv_c;
      end
    end
  end

  assign inv_a  = r_inv_a;
  assign resp_c = r_resp_c;

endmodule

// File: tb/tb_mod_inv_arbiter.sv
// Scoreboard bench for mod_inv_arbiter with a behavioural inverse engine (binary extended GCD).
module tb_mod_inv_arbiter;
  import sm2_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 256;

  typedef struct {
    logic [W-1:0] c;
    logic         err;
    logic         skip;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [W-1:0]      resp_c;
  logic              resp_err;
  logic [W-1:0]      inv_a;
  logic              inv_start;
  logic [W-1:0]      inv_c;
  logic              inv_done;
  logic              busy;
  logic              eng_done;
  logic              spur_done;

  int unsigned     drv_cnt [NREQ] = '{default: 0};
  int unsigned     acc_cnt [NREQ] = '{default: 0};
  logic [NREQ-1:0] acc_pend = '0;
  exp_t            exp_q [NREQ][$];
  int              served_q[$];
  int              n_checks = 0;
  int              n_errs = 0;
  int              cyc = 0;
  int              acc_cyc = 0;
  int              done_cyc = 0;
  int              n_starts = 0;
  int              rst_cnt = 0;
  int              eng_lat = 3;
  logic [W-1:0]    acc_op = '0;

  always #5 clk = ~clk;

  assign inv_done = eng_done | spur_done;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) req_valid[i] = (drv_cnt[i] != acc_cnt[i]);
  end

  mod_inv_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_c     (resp_c),
    .resp_err   (resp_err),
    .inv_a      (inv_a),
    .inv_start  (inv_start),
    .inv_c      (inv_c),
    .inv_done   (inv_done),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Binary extended GCD inverse modulo P; operands outside [1, P) map to 0.
  function automatic logic [W-1:0] mod_inv(input logic [W-1:0] a);
    logic [W:0] u, v, x1, x2;
    if (a == '0 || a >= P) return '0;
    u = {1'b0, a};
    v = {1'b0, P};
    x1 = 1;
    x2 = 0;
    while (u != 1 && v != 1) begin
      while (!u[0]) begin
        u  = u >> 1;
        x1 = x1[0] ? (x1 + P) >> 1 : x1 >> 1;
      end
      while (!v[0]) begin
        v  = v >> 1;
        x2 = x2[0] ? (x2 + P) >> 1 : x2 >> 1;
      end
      if (u >= v) begin
        u  = u - v;
        x1 = (x1 >= x2) ? x1 - x2 : x1 + P - x2;
      end else begin
        v  = v - u;
        x2 = (x2 >= x1) ? x2 - x1 : x2 + P - x1;
      end
    end
    return (u == 1) ? x1[W-1:0] : x2[W-1:0];
  endfunction

  function automatic int oh2id(input logic [NREQ-1:0] oh);
    for (int i = 0; i < NREQ; i++) if (oh[i]) return i;
    return 0;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    r[W-1] = 1'b0;
    r[0]   = 1'b1;
    return r;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input int id, input logic [W-1:0] a, input logic [W-1:0] c,
                       input logic err, input logic skip);
    exp_t e;
    e.c    = c;
    e.err  = err;
    e.skip = skip;
    exp_q[id].push_back(e);
    req_a[id*W +: W] = a;
    drv_cnt[id]++;
  endtask

  task automatic drive_auto(input int id, input logic [W-1:0] a);
    logic zc;
    zc = 1'b0;
`ifdef MOD_INV_ARB_ZERO_CHECK_EN
    zc = (a == '0) || (a == P);
`endif
    if (zc) drive(id, a, '0, 1'b1, 1'b1);
    else    drive(id, a, mod_inv(a), 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy && req_valid == '0 && all_empty()) begin
        ok = 1'b1;
        break;
      end
    end
    check_val(tag, W'(ok), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, W'(busy), 0);
    check_val({tag, "_req_ready"}, W'(req_ready), 0);
    check_val({tag, "_resp_valid"}, W'(resp_valid), 0);
    check_val({tag, "_inv_start"}, W'(inv_start), 0);
    check_val({tag, "_inv_a"}, inv_a, 0);
    check_val({tag, "_resp_c"}, resp_c, 0);
    check_val({tag, "_resp_err"}, W'(resp_err), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge rstn);
    rst_cnt++;
  end

  // Acceptances retire a request just after the edge that took it.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc_pend[i]) acc_cnt[i]++;
  end

  // Engine model: one result per start, abandoned if reset falls while it is working.
  initial begin
    logic [W-1:0] eng_a;
    int           eng_rc;
    eng_done = 1'b0;
    inv_c    = '0;
    forever begin
      @(negedge clk);
      if (rstn && inv_start) begin
        eng_a  = inv_a;
        eng_rc = rst_cnt;
        for (int k = 0; k < eng_lat; k++) begin
          @(posedge clk);
          if (rst_cnt != eng_rc) break;
        end
        #1;
        if (rst_cnt == eng_rc) begin
          eng_done = 1'b1;
          inv_c    = mod_inv(eng_a);
          @(posedge clk);
          #1;
          eng_done = 1'b0;
          inv_c    = '0;
        end
      end
    end
  end

  initial begin
    logic [NREQ-1:0] prev_rv;
    exp_t            e;
    int              id;
    prev_rv = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_rv  = '0;
        acc_pend = '0;
      end else begin
        acc_pend = req_valid & req_ready;
        if (acc_pend != '0) begin
          check_val("grant_onehot", W'($countones(req_ready)), 1);
          acc_cyc = cyc;
          acc_op  = req_a[oh2id(acc_pend)*W +: W];
        end
        if (inv_start) begin
          n_starts++;
          check_val("start_latency", W'(cyc), W'(acc_cyc + 1));
          check_val("inv_a_operand", inv_a, acc_op);
        end
        if (inv_done) done_cyc = cyc;
        if (resp_valid != '0 && prev_rv == '0) begin
          check_val("resp_onehot", W'($countones(resp_valid)), 1);
          id = oh2id(resp_valid);
          check_val("resp_outstanding", W'(exp_q[id].size()), 1);
          if (exp_q[id].size() != 0) begin
            if (exp_q[id][0].skip) check_val("resp_latency_skip", W'(cyc), W'(acc_cyc + 1));
            else                   check_val("resp_latency", W'(cyc), W'(done_cyc + 1));
          end
        end
        if ((resp_valid & resp_ready) != '0) begin
          id = oh2id(resp_valid);
          if (exp_q[id].size() != 0) begin
            e = exp_q[id].pop_front();
            check_val("resp_c", resp_c, e.c);
            check_val("resp_err", W'(resp_err), W'(e.err));
            served_q.push_back(id);
          end
        end
        prev_rv = resp_valid;
      end
    end
  end

  initial begin
    logic [W-1:0] held_c;
    int           n0;
    bit           seen;
    resp_ready = '1;
    req_a      = '0;
    spur_done  = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();

    // All four request A=1 together: served 0,1,2,3.
    for (int i = 0; i < NREQ; i++) drive(i, 1, 1, 1'b0, 1'b0);
    wait_idle("rr4_idle");
    check_val("rr4_count", W'(served_q.size()), 4);
    for (int i = 0; i < served_q.size(); i++) check_val("rr4_order", W'(served_q[i]), W'(i));
    served_q.delete();

    // Pointer wrapped to 0: requester 0 beats requester 3.
    tick();
    drive_auto(3, 5);
    drive_auto(0, 7);
    wait_idle("wrap_idle");
    check_val("wrap_count", W'(served_q.size()), 2);
    if (served_q.size() == 2) begin
      check_val("wrap_first", W'(served_q[0]), 0);
      check_val("wrap_second", W'(served_q[1]), 3);
    end
    served_q.delete();

    // Inverse of 2.
    tick();
    drive(0, 2, 256'h7FFFFFFF7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF800000008000000000000000,
          1'b0, 1'b0);
    wait_idle("inv2_idle");
    served_q.delete();

    // Requester 2 stalls its response for 10 cycles while requester 1 waits.
    resp_ready[2] = 1'b0;
    tick();
    drive_auto(2, rnd_op());
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (resp_valid[2]) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("hold_resp_seen", W'(seen), 1);
    held_c = resp_c;
    drive_auto(1, rnd_op());
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check_val("hold_resp_valid", W'(resp_valid), 4'b0100);
      check_val("hold_resp_c", resp_c, held_c);
      check_val("hold_no_ready", W'(req_ready), 0);
    end
    @(posedge clk);
    #1 resp_ready[2] = 1'b1;
    wait_idle("hold_idle");
    check_val("hold_count", W'(served_q.size()), 2);
    if (served_q.size() == 2) begin
      check_val("hold_first", W'(served_q[0]), 2);
      check_val("hold_second", W'(served_q[1]), 1);
    end
    served_q.delete();

    // Zero operand: bypass with error when the check is built in, engine otherwise.
    n0 = n_starts;
    tick();
    drive_auto(1, 0);
    wait_idle("zero_idle");
`ifdef MOD_INV_ARB_ZERO_CHECK_EN
    check_val("zero_no_start", W'(n_starts), W'(n0));
    tick();
    drive_auto(2, P);
    wait_idle("p_idle");
    check_val("p_no_start", W'(n_starts), W'(n0));
`else
    check_val("zero_engine_start", W'(n_starts), W'(n0 + 1));
`endif
    served_q.delete();

    // Reset while waiting on the engine.
    eng_lat = 20;
    tick();
    drive_auto(1, rnd_op());
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (inv_start) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("wait_start_seen", W'(seen), 1);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    served_q.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    eng_lat = 3;
    tick();
    drive_auto(3, rnd_op());
    #1;
    check_val("post_rst_grant", W'(req_ready), 4'b1000);
    wait_idle("post_rst_idle");
    check_val("post_rst_served", W'(served_q.size() == 1 ? served_q[0] : -1), 3);
    served_q.delete();

    // Spurious inv_done while idle.
    tick();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_val("spur_resp_valid", W'(resp_valid), 0);
      check_val("spur_busy", W'(busy), 0);
    end

    check_val("final_drained", W'(all_empty()), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/mod_inv_arbiter.md
MOD_INV_ARBITER -- requirements
Module: mod_inv_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one mod-p inverse engine.
REQ-002 Parameter W, default 256, operand and result width in bits.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_a  input  NREQ*W  operands, requester i in bits [i*W +: W].
REQ-007 req_ready  output  NREQ  one-hot acceptance; a request is accepted on the cycle where req_valid[i] and req_ready[i] are both high.
REQ-008 resp_valid  output  NREQ  one-hot result valid to the owning requester.
REQ-009 resp_ready  input  NREQ  per-requester result acknowledge.
REQ-010 resp_c  output  W  result A^-1 mod p.
REQ-011 resp_err  output  1  operand has no inverse; meaningful only while resp_valid is non-zero.
REQ-012 inv_a, inv_start  output  W, 1  engine operand and one-cycle start pulse.
REQ-013 inv_c, inv_done  input  W, 1  engine result, valid only in the single cycle inv_done is high.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, START, WAIT, RESP.
REQ-016 IDLE: the round-robin arbiter picks the first requester with req_valid set, searching upward from ptr with wrap-around; req_ready is high for that requester only, combinationally, and only in IDLE.
REQ-017 On acceptance: register the operand into inv_a, record the owner id, set ptr to (id+1) mod NREQ, then go to START.
REQ-018 START: inv_start=1 for exactly one cycle with inv_a stable, then go to WAIT.
REQ-019 inv_a holds its value from START until the next acceptance.
REQ-020 WAIT: on inv_done=1, capture inv_c into resp_c, set resp_err=0, then go to RESP; inv_done in any other state is ignored.
REQ-021 RESP: resp_valid[id]=1 with resp_c and resp_err held stable until resp_ready[id]=1; then return to IDLE on the next cycle.
REQ-022 resp_ready bits of non-owners have no effect.
REQ-023 A new request is never accepted before the return to IDLE; there is no back-to-back overlap.
REQ-024 Latency: acceptance at cycle T gives inv_start at T+1; resp_valid rises one cycle after inv_done.
REQ-025 Requests stay pending while not granted; a requester dropping req_valid before acceptance is not an error.

Reset
REQ-026 rstn low asynchronously forces: state IDLE, ptr 0, inv_start 0, inv_a 0, resp_c 0, resp_err 0, resp_valid 0, req_ready 0, busy 0.
REQ-027 Reset mid-operation abandons the transaction with no response; the engine is reset on the same rstn.

Configuration
REQ-028 Macro MOD_INV_ARB_ZERO_CHECK_EN.
REQ-029 When defined: an accepted operand equal to 0 or to p skips the engine, with no inv_start, and goes directly to RESP with resp_c=0 and resp_err=1; resp_valid rises at T+1.
REQ-030 When undefined: every operand goes through the engine and resp_err is tied to 0.

Structure
REQ-031 Shared package sm2_pkg holds the constant P (SM2 prime FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF), the W default and the FSM state typedef.
REQ-032 One sub-module, rr_arbiter (NREQ-wide round-robin pick from a req vector and ptr, giving a one-hot grant and a binary id), is natural.
REQ-033 The inverse engine sits outside this block and connects through the inv_* ports.

Verification
REQ-034 Requester 0 sends A=2 -> inv_start 1 cycle later; resp_valid[0] shows resp_c=7FFFFFFF7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF800000008000000000000000, resp_err=0.
REQ-035 Requesters 0..3 all request A=1 at once, held -> served in order 0,1,2,3, each resp_c=1; ptr wraps back to 0.
REQ-036 Requester 2 holds resp_ready low for 10 cycles -> resp_valid[2] and resp_c stable throughout; no req_ready seen; returns to IDLE after ack.
REQ-037 With the macro defined, A=0 -> no inv_start; resp_valid at T+1 with resp_err=1 and resp_c=0. Without the macro, A=0 goes to the engine.
REQ-038 rstn pulsed low in WAIT -> all outputs 0 at once; a following request from requester 3 is granted first since ptr=0 and no other requester is active.
REQ-039 A spurious inv_done pulse in IDLE -> no resp_valid and no state change.
